axi_lite_sram_slave: RTL and testbench
======================================

AXI_LITE_SRAM_SLAVE -- requirements
Module: axi_lite_sram_slave

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, the number of 32-bit words of storage (power of two).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, the byte address of word 0 (aligned to DEPTH_WORDS*4).
REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
- aclk  in  1  clock; all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- ar_addr  in  32  read byte address
- ar_prot  in  3  ignored
- ar_valid  in  1  read address valid
- ar_ready  out  1  slave accepts read address
- r_data  out  32  read data
- r_resp  out  2  read response
- r_valid  out  1  read data/response valid
- r_ready  in  1  master accepts read data
- aw_addr  in  32  write byte address
- aw_prot  in  3  ignored
- aw_valid  in  1  write address valid
- aw_ready  out  1  slave accepts write address
- w_data  in  32  write data
- w_strb  in  4  byte enables, bit i = w_data[8i+7:8i]
- w_valid  in  1  write data valid
- w_ready  out  1  slave accepts write data
- b_resp  out  2  write response
- b_valid  out  1  write response valid
- b_ready  in  1  master accepts write response

Function
REQ-004 Read and write paths SHALL be independent FSMs that operate concurrently.
REQ-005 Read FSM states SHALL be R_IDLE, R_READ and R_RESP; ar_ready = 1 only in R_IDLE.
REQ-006 On ar_valid && ar_ready the read FSM SHALL capture ar_addr and enter R_READ, then enter R_RESP on the next cycle with r_data and r_resp registered.
REQ-007 In R_RESP, r_valid SHALL be 1 with r_data and r_resp stable until r_valid && r_ready, after which the read FSM SHALL return to R_IDLE.
REQ-008 Read latency SHALL be: address handshake in cycle N, r_valid first high in cycle N+2.
REQ-009 Write FSM states SHALL be W_IDLE, W_MEM and W_RESP.
REQ-010 In W_IDLE, aw_ready SHALL equal !aw_held and w_ready SHALL equal !w_held, where the held flags are set on the respective handshake together with capture of the address, or of the data and strobe.
REQ-011 The AW and W handshakes SHALL be accepted in either order or in the same cycle.
REQ-012 When both held flags are set (counting same-cycle capture), the write FSM SHALL enter W_MEM, perform the strobed write in that cycle, then enter W_RESP.
REQ-013 Both held flags SHALL clear on entry to W_MEM.
REQ-014 aw_ready and w_ready SHALL be 0 in W_MEM and W_RESP.
REQ-015 In W_RESP, b_valid SHALL be 1 with b_resp stable until b_ready, after which the write FSM SHALL return to W_IDLE.
REQ-016 Write latency SHALL be: the later of the two handshakes in cycle N, b_valid first high in cycle N+2.
REQ-017 Word index SHALL be (addr - BASE_ADDR) >> 2; addr[1:0] SHALL be ignored.
REQ-018 An address is in range iff BASE_ADDR <= addr < BASE_ADDR + DEPTH_WORDS*4, compared in 33-bit arithmetic with no wrap.
REQ-019 For an in-range access, the response SHALL be OKAY (2'b00).
REQ-020 For an out-of-range read, the response SHALL be SLVERR (2'b10) with r_data = 0.
REQ-021 For an out-of-range write, the response SHALL be SLVERR (2'b10) and storage SHALL be unmodified.
REQ-022 Write strobes: only bytes with w_strb[i]=1 SHALL change; w_strb = 4'b0000 SHALL leave storage unchanged and return OKAY.
REQ-023 A read in R_READ and a write in W_MEM to the same word in the same cycle SHALL return the old data (read-first).
REQ-024 Back-to-back transactions: a new ar or aw/w handshake SHALL be accepted in the cycle after the previous response handshake completes; there is no outstanding-transaction queue (one read and one write in flight max).

Reset
REQ-025 While resetn = 0 at a rising edge, both FSMs SHALL go to IDLE and the held flags SHALL clear.
REQ-026 While resetn = 0 at a rising edge, r_valid, b_valid, r_data and r_resp/b_resp SHALL be 0.
REQ-027 During reset, ar_ready, aw_ready and w_ready SHALL be 0; in the first cycle after reset they SHALL be 1.
REQ-028 Reset mid-transaction SHALL abandon it with no response issued; a write not yet in W_MEM SHALL not modify storage.
REQ-029 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-030 Shared package axi_lite_pkg SHALL hold RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, and the read and write state enums.
REQ-031 Storage SHALL be a sub-module sram_dp_be: one registered read port and one write port with 4 byte enables, DEPTH_WORDS x 32, read-first.

Verification
REQ-032 Write 0xDEADBEEF to 0x10 with strb 4'b1111, then read 0x10 -> b_resp 00; r_data 0xDEADBEEF, r_resp 00, r_valid 2 cycles after the ar handshake.
REQ-033 Write 0x11223344 to 0x10, then write 0xAABBCCDD with strb 4'b0101 to 0x10, then read -> 0x11BB33DD.
REQ-034 W handshake 3 cycles before AW handshake -> w_ready low after capture; single write; b_valid 2 cycles after the AW handshake.
REQ-035 Read BASE_ADDR + DEPTH_WORDS*4 and write 0xFFFFFFFC -> r_resp 10 with r_data 0; b_resp 10; storage unchanged.
REQ-036 r_ready held low 5 cycles -> r_valid and r_data stable throughout; simultaneous read and write to 0x20 (old 0x1) -> read returns 0x1, later read returns the new value.
REQ-037 resetn low for 1 cycle while in W_RESP -> b_valid 0, then ready outputs return to 1, and the next transaction completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes, FSM state encodings, address range helper.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_MEM, W_RESP} wr_state_e;

  // 33-bit compare so a window ending at 4 GiB cannot wrap.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] span);
    logic [32:0] a;
    logic [32:0] b;
    a = {1'b0, addr};
    b = {1'b0, base};
    return (a >= b) && (a < (b + span));
  endfunction

endpackage

// File: rtl/sram_dp_be.sv
// DEPTH_WORDS x 32 storage: one registered read port, one byte-enabled write port, read-first.
module sram_dp_be #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           i_clk,
  input  logic                           i_rd_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_rd_idx,
  output logic [31:0]                    o_rd_q,
  input  logic                           i_wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_wr_idx,
  input  logic [3:0]                     i_wr_be,
  input  logic [31:0]                    i_wr_d
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_q;

  // Non-blocking read and write in one process gives old data on a same-word collision.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) r_q <= r_mem[i_rd_idx];
    if (i_wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (i_wr_be[b]) r_mem[i_wr_idx][8*b +: 8] <= i_wr_d[8*b +: 8];
      end
    end
  end

  assign o_rd_q = r_q;

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave fronting a byte-enabled SRAM; independent read and write FSMs.
module axi_lite_sram_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        resetn,
  input  logic [31:0] ar_addr,
  input  logic [2:0]  ar_prot,
  input  logic        ar_valid,
  output logic        ar_ready,
  output logic [31:0] r_data,
  output logic [1:0]  r_resp,
  output logic        r_valid,
  input  logic        r_ready,
  input  logic [31:0] aw_addr,
  input  logic [2:0]  aw_prot,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic [31:0] w_data,
  input  logic [3:0]  w_strb,
  input  logic        w_valid,
  output logic        w_ready,
  output logic [1:0]  b_resp,
  output logic        b_valid,
  input  logic        b_ready
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  rd_state_e   r_rd_state, w_rd_next;
  logic [31:0] r_ar_addr;
  logic        r_rd_ok;
  logic [1:0]  r_r_resp;
  logic [31:0] w_rd_off;
  logic        w_rd_in_range;
  logic        w_ar_hs;
  logic [31:0] w_sram_q;

  wr_state_e   r_wr_state, w_wr_next;
  logic [31:0] r_aw_addr;
  logic [31:0] r_w_data;
  logic [3:0]  r_w_strb;
  logic        r_aw_held, r_w_held;
  logic [1:0]  r_b_resp;
  logic [31:0] w_wr_off;
  logic        w_wr_in_range;
  logic        w_aw_hs, w_w_hs;

  assign w_rd_off      = r_ar_addr - BASE_ADDR;
  assign w_rd_in_range = addr_in_range(r_ar_addr, BASE_ADDR, SPAN);
  assign w_wr_off      = r_aw_addr - BASE_ADDR;
  assign w_wr_in_range = addr_in_range(r_aw_addr, BASE_ADDR, SPAN);

  assign w_ar_hs = ar_valid && ar_ready;
  assign w_aw_hs = aw_valid && aw_ready;
  assign w_w_hs  = w_valid && w_ready;

  // Ready outputs are gated by resetn so they read low while reset is asserted.
  always_comb begin
    w_rd_next = r_rd_state;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    unique case (r_rd_state)
      R_IDLE: begin
        ar_ready = resetn;
        if (w_ar_hs) w_rd_next = R_READ;
      end
      R_READ: w_rd_next = R_RESP;
      R_RESP: begin
        r_valid = 1'b1;
        if (r_ready) w_rd_next = R_IDLE;
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_rd_state <= R_IDLE;
      r_rd_ok    <= 1'b0;
      r_r_resp   <= RESP_OKAY;
    end else begin
      r_rd_state <= w_rd_next;
      if (w_ar_hs) r_ar_addr <= ar_addr;
      if (r_rd_state == R_READ) begin
        r_rd_ok  <= w_rd_in_range;
        r_r_resp <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign r_data = r_rd_ok ? w_sram_q : '0;
  assign r_resp = r_r_resp;

  always_comb begin
    w_wr_next = r_wr_state;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    unique case (r_wr_state)
      W_IDLE: begin
        aw_ready = resetn && !r_aw_held;
        w_ready  = resetn && !r_w_held;
        if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) w_wr_next = W_MEM;
      end
      W_MEM: w_wr_next = W_RESP;
      W_RESP: begin
        b_valid = 1'b1;
        if (b_ready) w_wr_next = W_IDLE;
      end
      default: w_wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_wr_state <= W_IDLE;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_b_resp   <= RESP_OKAY;
    end else begin
      r_wr_state <= w_wr_next;
      if (w_aw_hs) begin
        r_aw_addr <= aw_addr;
        r_aw_held <= 1'b1;
      end
      if (w_w_hs) begin
        r_w_data <= w_data;
        r_w_strb <= w_strb;
        r_w_held <= 1'b1;
      end
      if (r_wr_state == W_IDLE && w_wr_next == W_MEM) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
      if (r_wr_state == W_MEM) r_b_resp <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign b_resp = r_b_resp;

  sram_dp_be #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .i_clk    (aclk),
    .i_rd_en  ((r_rd_state == R_READ) && w_rd_in_range),
    .i_rd_idx (w_rd_off[AW+1:2]),
    .o_rd_q   (w_sram_q),
    .i_wr_en  ((r_wr_state == W_MEM) && w_wr_in_range),
    .i_wr_idx (w_wr_off[AW+1:2]),
    .i_wr_be  (r_w_strb),
    .i_wr_d   (r_w_data)
  );

  logic w_unused_ok;
  assign w_unused_ok = ^{ar_prot, aw_prot, w_rd_off[31:AW+2], w_rd_off[1:0],
                         w_wr_off[31:AW+2], w_wr_off[1:0]};

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed scoreboard bench for axi_lite_sram_slave (DEPTH_WORDS=1024, BASE_ADDR=0).
module tb_axi_lite_sram_slave;

  logic        aclk = 1'b0;
  logic        resetn;
  logic [31:0] ar_addr;
  logic [2:0]  ar_prot;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] aw_addr;
  logic [2:0]  aw_prot;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  rexp_t      exp_r[$];
  logic [1:0] exp_b[$];
  int         checks = 0;
  int         errors = 0;

  always #5 aclk = ~aclk;

  axi_lite_sram_slave #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .aclk(aclk), .resetn(resetn),
    .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response handshake is about to complete.
  always @(negedge aclk) begin
    if (r_valid && r_ready) begin
      if (exp_r.size() == 0) check("r_unexpected", 32'd1, 32'd0);
      else begin
        rexp_t e;
        e = exp_r.pop_front();
        check("r_data", r_data, e.data);
        check("r_resp", 32'(r_resp), 32'(e.resp));
      end
    end
    if (b_valid && b_ready) begin
      if (exp_b.size() == 0) check("b_unexpected", 32'd1, 32'd0);
      else check("b_resp", 32'(b_resp), 32'(exp_b.pop_front()));
    end
  end

  // sel: 0 ar_ready, 1 w_ready, 2 aw_ready&&w_ready, 3 aw_ready
  task automatic wait_ready(input int sel);
    int  n;
    logic ok;
    n = 0;
    @(negedge aclk);
    forever begin
      case (sel)
        0:       ok = ar_ready;
        1:       ok = w_ready;
        2:       ok = aw_ready && w_ready;
        default: ok = aw_ready;
      endcase
      if (ok || n >= 50) break;
      @(negedge aclk);
      n++;
    end
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] edata,
                    input logic [1:0] eresp, input int hold);
    rexp_t e;
    e.data = edata;
    e.resp = eresp;
    exp_r.push_back(e);
    @(posedge aclk) #1;
    ar_addr  = addr;
    ar_valid = 1'b1;
    wait_ready(0);
    @(posedge aclk) #1;
    ar_valid = 1'b0;
    @(negedge aclk) check("rd_lat_n1", 32'(r_valid), 32'd0);
    @(negedge aclk) check("rd_lat_n2", 32'(r_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      check("r_hold_valid", 32'(r_valid), 32'd1);
      check("r_hold_data", r_data, edata);
    end
    @(posedge aclk) #1;
    r_ready = 1'b1;
    @(posedge aclk) #1;
    r_ready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic [1:0] eresp, input int w_lead);
    exp_b.push_back(eresp);
    @(posedge aclk) #1;
    w_data = data;
    w_strb = strb;
    if (w_lead > 0) begin
      w_valid = 1'b1;
      wait_ready(1);
      @(posedge aclk) #1;
      w_valid = 1'b0;
      for (int i = 0; i < w_lead - 1; i++) begin
        @(negedge aclk) check("w_held_ready", 32'(w_ready), 32'd0);
        @(posedge aclk) #1;
      end
      aw_addr  = addr;
      aw_valid = 1'b1;
      wait_ready(3);
    end else begin
      aw_addr  = addr;
      aw_valid = 1'b1;
      w_valid  = 1'b1;
      wait_ready(2);
    end
    @(posedge aclk) #1;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    @(negedge aclk) check("wr_lat_n1", 32'(b_valid), 32'd0);
    @(negedge aclk) check("wr_lat_n2", 32'(b_valid), 32'd1);
    @(posedge aclk) #1;
    b_ready = 1'b1;
    @(posedge aclk) #1;
    b_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    ar_addr = '0; ar_prot = '0; ar_valid = 1'b0; r_ready = 1'b0;
    aw_addr = '0; aw_prot = '0; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_valid = 1'b0; b_ready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_ar_ready", 32'(ar_ready), 32'd0);
    check("rst_aw_ready", 32'(aw_ready), 32'd0);
    check("rst_w_ready", 32'(w_ready), 32'd0);
    check("rst_r_valid", 32'(r_valid), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_r_data", r_data, 32'd0);
    check("rst_r_resp", 32'(r_resp), 32'd0);
    check("rst_b_resp", 32'(b_resp), 32'd0);
    @(posedge aclk) #1;
    resetn = 1'b1;
    @(negedge aclk);
    check("post_rst_ar_ready", 32'(ar_ready), 32'd1);
    check("post_rst_aw_ready", 32'(aw_ready), 32'd1);
    check("post_rst_w_ready", 32'(w_ready), 32'd1);

    wr(32'h10, 32'hDEADBEEF, 4'b1111, 2'b00, 0);
    rd(32'h10, 32'hDEADBEEF, 2'b00, 0);

    wr(32'h10, 32'h11223344, 4'b1111, 2'b00, 0);
    wr(32'h10, 32'hAABBCCDD, 4'b0101, 2'b00, 0);
    rd(32'h10, 32'h11BB33DD, 2'b00, 0);
    wr(32'h10, 32'hCAFEF00D, 4'b0000, 2'b00, 0);
    rd(32'h10, 32'h11BB33DD, 2'b00, 0);

    wr(32'h40, 32'h0BADF00D, 4'b1111, 2'b00, 3);
    rd(32'h40, 32'h0BADF00D, 2'b00, 0);

    wr(32'hFFC, 32'h12345678, 4'b1111, 2'b00, 0);
    wr(32'h0, 32'h0000A5A5, 4'b1111, 2'b00, 0);
    rd(32'h1000, 32'h0, 2'b10, 0);
    wr(32'hFFFFFFFC, 32'hFFFFFFFF, 4'b1111, 2'b10, 0);
    wr(32'h1000, 32'hFFFFFFFF, 4'b1111, 2'b10, 0);
    rd(32'hFFC, 32'h12345678, 2'b00, 0);
    rd(32'hFFF, 32'h12345678, 2'b00, 0);
    rd(32'h0, 32'h0000A5A5, 2'b00, 0);

    wr(32'h20, 32'h1, 4'b1111, 2'b00, 0);
    rd(32'h20, 32'h1, 2'b00, 5);
    fork
      rd(32'h20, 32'h1, 2'b00, 0);
      wr(32'h20, 32'h2222, 4'b1111, 2'b00, 0);
    join
    rd(32'h20, 32'h2222, 2'b00, 0);

    // Reset while the write response is pending: no response may be issued.
    @(posedge aclk) #1;
    aw_addr = 32'h50; aw_valid = 1'b1;
    w_data = 32'h77; w_strb = 4'b1111; w_valid = 1'b1;
    wait_ready(2);
    @(posedge aclk) #1;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    @(negedge aclk);
    @(negedge aclk) check("pre_rst_b_valid", 32'(b_valid), 32'd1);
    @(posedge aclk) #1;
    resetn = 1'b0;
    @(negedge aclk);
    check("mid_rst_ar_ready", 32'(ar_ready), 32'd0);
    check("mid_rst_aw_ready", 32'(aw_ready), 32'd0);
    check("mid_rst_w_ready", 32'(w_ready), 32'd0);
    @(posedge aclk) #1;
    resetn = 1'b1;
    @(negedge aclk);
    check("after_rst_b_valid", 32'(b_valid), 32'd0);
    check("after_rst_b_resp", 32'(b_resp), 32'd0);
    check("after_rst_aw_ready", 32'(aw_ready), 32'd1);
    check("after_rst_w_ready", 32'(w_ready), 32'd1);
    check("after_rst_ar_ready", 32'(ar_ready), 32'd1);
    rd(32'h50, 32'h77, 2'b00, 0);
    wr(32'h54, 32'h5A5A5A5A, 4'b1111, 2'b00, 0);
    rd(32'h54, 32'h5A5A5A5A, 2'b00, 0);

    // Write data accepted, then reset before the address arrives: storage untouched.
    wr(32'h30, 32'h55, 4'b1111, 2'b00, 0);
    @(posedge aclk) #1;
    w_data = 32'h99; w_strb = 4'b1111; w_valid = 1'b1;
    wait_ready(1);
    @(posedge aclk) #1;
    w_valid = 1'b0;
    @(negedge aclk) check("w_only_held", 32'(w_ready), 32'd0);
    @(posedge aclk) #1;
    resetn = 1'b0;
    @(posedge aclk) #1;
    resetn = 1'b1;
    @(negedge aclk) check("w_held_cleared", 32'(w_ready), 32'd1);
    rd(32'h30, 32'h55, 2'b00, 0);

    repeat (3) @(posedge aclk);
    check("r_queue_empty", 32'(exp_r.size()), 32'd0);
    check("b_queue_empty", 32'(exp_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
